// File: rtl/demux_deser2_8b_rtl.sv
// Serial-to-parallel deserializer: assembles LSB-first bits into a byte and
// routes it to one of two channels chosen by the select seen on the first bit.
module demux_deser2_8b_rtl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_val,
  input  logic       in_bit,
  input  logic       in_sel,
  input  logic       out0_rdy,
  input  logic       out1_rdy,
  output logic       busy,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic       out0_val,
  output logic       out1_val
);

  // Handshake: a byte is offered while out<n>_val=1 and is consumed on the
  // rising edge where out<n>_rdy=1; upstream bits are accepted only while the
  // block is not holding a byte (busy=1 in HOLD means input bits are dropped).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [2:0]  count_q, count_n;
  logic        sel_q, sel_n;
  logic [7:0]  asm_q, asm_n;
  logic [7:0]  out0_q, out0_n;
  logic [7:0]  out1_q, out1_n;
  logic [7:0]  byte_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 3'd0;
      sel_q   <= 1'b0;
      asm_q   <= 8'h00;
      out0_q  <= 8'h00;
      out1_q  <= 8'h00;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      sel_q   <= sel_n;
      asm_q   <= asm_n;
      out0_q  <= out0_n;
      out1_q  <= out1_n;
    end
  end

  // The final bit bypasses the assembly register so the byte lands in the
  // output register on the same edge that HOLD is entered.
  assign byte_done = {in_bit, asm_q[6:0]};

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    sel_n   = sel_q;
    asm_n   = asm_q;
    out0_n  = out0_q;
    out1_n  = out1_q;
    unique case (state_q)
      IDLE: begin
        if (in_val) begin
          asm_n[0] = in_bit;
          sel_n    = in_sel;
          count_n  = 3'd1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (in_val) begin
          asm_n[count_q] = in_bit;
          count_n        = count_q + 3'd1;
          if (count_q == 3'd7) begin
            state_n = HOLD;
            if (sel_q) out1_n = byte_done;
            else       out0_n = byte_done;
          end
        end
      end
      HOLD: begin
        if (sel_q ? out1_rdy : out0_rdy) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign out0     = out0_q;
  assign out1     = out1_q;
  assign out0_val = (state_q == HOLD) && !sel_q;
  assign out1_val = (state_q == HOLD) &&  sel_q;

endmodule
